// File: rtl/gamepad_pkg.sv
// Shared constants for the SNES-style gamepad poller: FSM encodings, bit map of the
// 16-bit serial frame, and a small helper for cancelling opposing directions.
package gamepad_pkg;

    localparam int unsigned NUM_BITS = 16;

    localparam int unsigned BTN_B      = 0;
    localparam int unsigned BTN_Y      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;
    localparam int unsigned BTN_A      = 8;
    localparam int unsigned BTN_X      = 9;
    localparam int unsigned BTN_L      = 10;
    localparam int unsigned BTN_R      = 11;
    localparam int unsigned ID_LSB     = 12;

    typedef logic [ID_LSB-1:0] btn_vec_t;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_LATCH = 3'd1;
    localparam state_t ST_GAP   = 3'd2;
    localparam state_t ST_LOW   = 3'd3;
    localparam state_t ST_HIGH  = 3'd4;
    localparam state_t ST_DONE  = 3'd5;

    // Returns {a_out, b_out}; both drop to 0 when a and b are pressed together.
    function automatic logic [1:0] resolve_pair(input logic a, input logic b);
        return {a & ~b, b & ~a};
    endfunction

endpackage

// File: rtl/gamepad_reader_if.sv
// Button-level interface between the gamepad poller (master) and the game logic (slave).
interface gamepad_reader_if;

    logic        up;
    logic        down;
    logic        left;
    logic        right;
    logic        pause;
    logic        restart;
    logic        connected;
    logic        valid;
    logic [11:0] buttons;

    modport master (
        output up, down, left, right, pause, restart, connected, valid, buttons
    );

    modport slave (
        input up, down, left, right, pause, restart, connected, valid, buttons
    );

endinterface

// File: rtl/gamepad_phase_timer.sv
// Down-counter for pad phase lengths: load with (length - 1), phase_end_o is high on the
// phase's last cycle.
module gamepad_phase_timer #(
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [Width-1:0] len_i,
    output logic             phase_end_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = len_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign phase_end_o = (cnt_q == '0);

endmodule

// File: rtl/gamepad_reader.sv
// SNES-style gamepad poller: drives latch/clock, shifts in 16 active-low bits and decodes
// them into game button levels. Optional macro GAMEPAD_DEBOUNCE_EN accepts a frame only
// when its decoded buttons match the previous frame.
module gamepad_reader
    import gamepad_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 150,
    parameter int unsigned POLL_CYCLES = 420000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_pad_data,
    output logic             o_pad_latch,
    output logic             o_pad_clk,
    gamepad_reader_if.master btn_if
);

    localparam int unsigned TimerW = $clog2(2 * HALF_PERIOD + 1);
    localparam int unsigned PollW  = $clog2(POLL_CYCLES);
    localparam int unsigned BitW   = $clog2(NUM_BITS);

    localparam logic [TimerW-1:0] LenLatch = TimerW'(2 * HALF_PERIOD - 1);
    localparam logic [TimerW-1:0] LenHalf  = TimerW'(HALF_PERIOD - 1);
    localparam logic [PollW-1:0]  PollLast = PollW'(POLL_CYCLES - 1);
    localparam logic [BitW-1:0]   BitLast  = BitW'(NUM_BITS - 1);

    state_t                state_q, state_d;
    logic [PollW-1:0]      poll_q, poll_d;
    logic [BitW-1:0]       bit_q, bit_d;
    logic [NUM_BITS-1:0]   shift_q, shift_d;
    logic                  pad_latch_q, pad_latch_d;
    logic                  pad_clk_q, pad_clk_d;

    logic                  timer_load;
    logic [TimerW-1:0]     timer_len;
    logic                  phase_end;

    gamepad_phase_timer #(
        .Width(TimerW)
    ) u_phase_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (timer_load),
        .len_i      (timer_len),
        .phase_end_o(phase_end)
    );

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        timer_load = 1'b0;
        timer_len  = LenHalf;
        poll_d     = (poll_q == PollLast) ? '0 : poll_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (poll_q == '0) begin
                    state_d    = ST_LATCH;
                    timer_load = 1'b1;
                    timer_len  = LenLatch;
                end
            end
            ST_LATCH: begin
                if (phase_end) begin
                    state_d    = ST_GAP;
                    timer_load = 1'b1;
                end
            end
            ST_GAP: begin
                if (phase_end) begin
                    state_d    = ST_LOW;
                    bit_d      = '0;
                    timer_load = 1'b1;
                end
            end
            ST_LOW: begin
                // Pad data is stable for the whole low phase; take it at the very end.
                if (phase_end) begin
                    shift_d[bit_q] = ~i_pad_data;
                    state_d        = ST_HIGH;
                    timer_load     = 1'b1;
                end
            end
            ST_HIGH: begin
                if (phase_end) begin
                    if (bit_q == BitLast) begin
                        state_d = ST_DONE;
                    end else begin
                        bit_d      = bit_q + 1'b1;
                        state_d    = ST_LOW;
                        timer_load = 1'b1;
                    end
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        pad_latch_d = (state_d == ST_LATCH);
        pad_clk_d   = (state_d != ST_LOW);
    end

    // Frame decode: a pad with any ID bit pressed is treated as absent.
    logic     frame_done;
    logic     connected;
    btn_vec_t btn;
    logic     accept;

    assign frame_done = (state_q == ST_DONE);
    assign connected  = (shift_q[NUM_BITS-1:ID_LSB] == '0);
    assign btn        = connected ? shift_q[ID_LSB-1:0] : '0;

`ifdef GAMEPAD_DEBOUNCE_EN
    btn_vec_t cand_q, cand_d;

    always_comb begin
        cand_d = frame_done ? btn : cand_q;
        accept = frame_done && (btn == cand_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q <= '0;
        end else begin
            cand_q <= cand_d;
        end
    end
`else
    assign accept = frame_done;
`endif

    logic     up_q, up_d, down_q, down_d, left_q, left_d, right_q, right_d;
    logic     pause_q, pause_d, restart_q, restart_d, conn_q, conn_d, valid_q, valid_d;
    logic     start_prev_q, start_prev_d;
    btn_vec_t buttons_q, buttons_d;
    logic [1:0] ud_res, lr_res;

    always_comb begin
        ud_res       = resolve_pair(btn[BTN_UP], btn[BTN_DOWN]);
        lr_res       = resolve_pair(btn[BTN_LEFT], btn[BTN_RIGHT]);
        up_d         = up_q;
        down_d       = down_q;
        left_d       = left_q;
        right_d      = right_q;
        pause_d      = pause_q;
        restart_d    = restart_q;
        conn_d       = conn_q;
        buttons_d    = buttons_q;
        start_prev_d = start_prev_q;
        valid_d      = accept;

        if (accept) begin
            {up_d, down_d}    = ud_res;
            {left_d, right_d} = lr_res;
            restart_d         = btn[BTN_SELECT];
            conn_d            = connected;
            buttons_d         = btn;
            start_prev_d      = btn[BTN_START];
            if (btn[BTN_SELECT]) begin
                pause_d = 1'b0;
            end else if (btn[BTN_START] && !start_prev_q) begin
                pause_d = ~pause_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            poll_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            pad_latch_q  <= 1'b0;
            pad_clk_q    <= 1'b1;
            up_q         <= 1'b0;
            down_q       <= 1'b0;
            left_q       <= 1'b0;
            right_q      <= 1'b0;
            pause_q      <= 1'b0;
            restart_q    <= 1'b0;
            conn_q       <= 1'b0;
            valid_q      <= 1'b0;
            buttons_q    <= '0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            poll_q       <= poll_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            pad_latch_q  <= pad_latch_d;
            pad_clk_q    <= pad_clk_d;
            up_q         <= up_d;
            down_q       <= down_d;
            left_q       <= left_d;
            right_q      <= right_d;
            pause_q      <= pause_d;
            restart_q    <= restart_d;
            conn_q       <= conn_d;
            valid_q      <= valid_d;
            buttons_q    <= buttons_d;
            start_prev_q <= start_prev_d;
        end
    end

    assign o_pad_latch       = pad_latch_q;
    assign o_pad_clk         = pad_clk_q;
    assign btn_if.up         = up_q;
    assign btn_if.down       = down_q;
    assign btn_if.left       = left_q;
    assign btn_if.right      = right_q;
    assign btn_if.pause      = pause_q;
    assign btn_if.restart    = restart_q;
    assign btn_if.connected  = conn_q;
    assign btn_if.valid      = valid_q;
    assign btn_if.buttons    = buttons_q;

endmodule
